// File: rtl/energy_monitor_pkg.sv
// Shared types and constants for the energy monitor pipeline.
// Holds the spin vector assembler FSM encoding and perf counter width.
package energy_monitor_pkg;

    typedef enum logic {
        ASM_FILL  = 1'b0,
        ASM_VALID = 1'b1
    } asm_state_e;

    localparam int PERF_CNT_WIDTH = 32;

endpackage

// File: rtl/spin_asm_word_counter.sv
// Mod-NUM_WORDS word index counter for the streaming stages.
// clr_i has priority over inc_i; last_o flags the final index.
module spin_asm_word_counter #(
    parameter int NUM_WORDS = 8,
    parameter int CNTWIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [CNTWIDTH-1:0] idx_o,
    output logic                last_o
);

    localparam logic [CNTWIDTH-1:0] LAST_IDX = CNTWIDTH'(NUM_WORDS - 1);

    assign last_o = (idx_o == LAST_IDX);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            idx_o <= '0;
        end else if (inc_i) begin
            if (last_o) begin
                idx_o <= '0;
            end else begin
                idx_o <= idx_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spin_vector_assembler.sv
// Assembles narrow stream words into one DATAWIDTH-bit spin vector.
// Define SPIN_ASM_PERF_EN to add delivered-vector and stall counters.
module spin_vector_assembler
    import energy_monitor_pkg::*;
#(
    parameter int DATAWIDTH = 256,
    parameter int WORDWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 flush_i,
    input  logic                 word_valid_i,
    output logic                 word_ready_o,
    input  logic [WORDWIDTH-1:0] word_i,
    output logic                 vec_valid_o,
    input  logic                 vec_ready_i,
    output logic [DATAWIDTH-1:0] vec_o
`ifdef SPIN_ASM_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] vec_count_o,
    output logic [PERF_CNT_WIDTH-1:0] stall_count_o
`endif
);

    localparam int NUM_WORDS = DATAWIDTH / WORDWIDTH;
    localparam int CNTWIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    if (DATAWIDTH % WORDWIDTH != 0) begin : g_bad_ratio
        $error("DATAWIDTH must be a multiple of WORDWIDTH");
    end
    if (NUM_WORDS < 1) begin : g_bad_words
        $error("NUM_WORDS must be at least 1");
    end

    asm_state_e          state_q;
    asm_state_e          state_d;
    logic [CNTWIDTH-1:0] idx;
    logic                idx_last;
    logic                word_hs;
    logic                vec_hs;

    assign word_ready_o = en_i & ~flush_i & ~rst_i & (state_q == ASM_FILL);
    assign word_hs      = word_valid_i & word_ready_o;
    assign vec_valid_o  = (state_q == ASM_VALID);
    // A flush in the same cycle cancels the downstream transfer.
    assign vec_hs       = vec_valid_o & vec_ready_i & en_i & ~flush_i & ~rst_i;

    spin_asm_word_counter #(
        .NUM_WORDS (NUM_WORDS),
        .CNTWIDTH  (CNTWIDTH)
    ) u_word_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .inc_i  (word_hs),
        .idx_o  (idx),
        .last_o (idx_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ASM_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ASM_FILL;
        end else begin
            unique case (state_q)
                ASM_FILL: begin
                    if (word_hs && idx_last) begin
                        state_d = ASM_VALID;
                    end
                end
                ASM_VALID: begin
                    if (vec_hs) begin
                        state_d = ASM_FILL;
                    end
                end
                default: state_d = ASM_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vec_o <= '0;
        end else if (word_hs) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (idx == CNTWIDTH'(k)) begin
                    vec_o[k*WORDWIDTH +: WORDWIDTH] <= word_i;
                end
            end
        end
    end

`ifdef SPIN_ASM_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vec_count_o   <= '0;
            stall_count_o <= '0;
        end else begin
            if (vec_hs) begin
                vec_count_o <= vec_count_o + 1'b1;
            end
            if (vec_valid_o && !vec_ready_i && en_i) begin
                stall_count_o <= stall_count_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spin_vector_assembler.sv
// Randomized and directed checks of spin_vector_assembler against a
// queue-based reference model of word collection and vector delivery.
module tb_spin_vector_assembler;

    localparam int DW = 256;
    localparam int WW = 32;
    localparam int NW = DW / WW;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          en_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          word_valid_i = 1'b0;
    logic          word_ready_o;
    logic [WW-1:0] word_i = '0;
    logic          vec_valid_o;
    logic          vec_ready_i = 1'b0;
    logic [DW-1:0] vec_o;
`ifdef SPIN_ASM_PERF_EN
    logic [31:0]   vec_count_o;
    logic [31:0]   stall_count_o;
`endif

    spin_vector_assembler #(
        .DATAWIDTH (DW),
        .WORDWIDTH (WW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .flush_i       (flush_i),
        .word_valid_i  (word_valid_i),
        .word_ready_o  (word_ready_o),
        .word_i        (word_i),
        .vec_valid_o   (vec_valid_o),
        .vec_ready_i   (vec_ready_i),
        .vec_o         (vec_o)
`ifdef SPIN_ASM_PERF_EN
        ,
        .vec_count_o   (vec_count_o),
        .stall_count_o (stall_count_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: words collected so far, and the finished vector.
    logic [WW-1:0] m_words[$];
    logic          m_pending = 1'b0;
    logic [DW-1:0] m_vec = '0;
    logic          m_after_rst = 1'b0;
    int unsigned   m_vcount = 0;
    int unsigned   m_stall = 0;
    int            delivered = 0;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic en,
                        input logic wv, input logic [WW-1:0] w,
                        input logic vr);
        @(negedge clk);
        rst_i = rst;
        flush_i = fl;
        en_i = en;
        word_valid_i = wv;
        word_i = w;
        vec_ready_i = vr;
        #1;
        check("word_ready", DW'(word_ready_o),
              DW'(en & ~fl & ~rst & ~m_pending));
        check("vec_valid", DW'(vec_valid_o), DW'(m_pending));
        if (m_pending) check("vec_data", vec_o, m_vec);
        if (m_after_rst) check("vec_reset", vec_o, '0);
`ifdef SPIN_ASM_PERF_EN
        check("vec_count", DW'(vec_count_o), DW'(m_vcount));
        check("stall_count", DW'(stall_count_o), DW'(m_stall));
`endif
        @(posedge clk);
        m_after_rst = rst;
        if (rst) begin
            m_words.delete();
            m_pending = 1'b0;
            m_vec = '0;
            m_vcount = 0;
            m_stall = 0;
        end else begin
            if (m_pending && !vr && en) m_stall++;
            if (fl) begin
                m_words.delete();
                m_pending = 1'b0;
            end else if (en) begin
                if (!m_pending && wv) begin
                    m_words.push_back(w);
                    if (m_words.size() == NW) begin
                        for (int k = 0; k < NW; k++)
                            m_vec[k*WW +: WW] = m_words[k];
                        m_words.delete();
                        m_pending = 1'b1;
                    end
                end else if (m_pending && vr) begin
                    m_pending = 1'b0;
                    m_vcount++;
                    delivered++;
                end
            end
        end
    endtask

    initial begin
        logic [DW-1:0] exp_vec;
        int d0;

        step(1, 0, 1, 1, 32'hdead, 1);
        step(1, 0, 1, 0, 0, 0);

        // Words 0..7, then immediate handshake.
        for (int k = 0; k < NW; k++) step(0, 0, 1, 1, WW'(k), 1);
        for (int k = 0; k < NW; k++) exp_vec[k*WW +: WW] = WW'(k);
        check("plan1_vec", m_vec, exp_vec);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);

        // Backpressure for 5 cycles, then accept.
        for (int k = 0; k < NW; k++) step(0, 0, 1, 1, 32'h100 + WW'(k), 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 1, 32'h55, 0);
        step(0, 0, 1, 1, 32'h55, 1);
        step(0, 0, 1, 0, 0, 0);

        // Partial vector then flush; only the A0..A7 vector appears.
        d0 = delivered;
        for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 32'hF0 + WW'(k), 0);
        step(0, 1, 1, 1, 32'hFF, 0);
        for (int k = 0; k < NW; k++) step(0, 0, 1, 1, 32'hA0 + WW'(k), 0);
        for (int k = 0; k < NW; k++) exp_vec[k*WW +: WW] = 32'hA0 + WW'(k);
        check("plan3_vec", m_vec, exp_vec);
        step(0, 0, 1, 0, 0, 1);
        check("plan3_count", DW'(delivered - d0), DW'(1));

        // Enable drop mid-vector.
        for (int k = 0; k < 4; k++) step(0, 0, 1, 1, 32'hC0 + WW'(k), 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 32'hC4, 1);
        for (int k = 4; k < NW; k++) step(0, 0, 1, 1, 32'hC0 + WW'(k), 0);
        for (int k = 0; k < NW; k++) exp_vec[k*WW +: WW] = 32'hC0 + WW'(k);
        check("plan4_vec", m_vec, exp_vec);
        step(0, 0, 0, 0, 0, 1);

        // Reset while VALID with downstream ready.
        step(1, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);

        // Flush racing a vector handshake.
        for (int k = 0; k < NW; k++) step(0, 0, 1, 1, $urandom, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom,
                 ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
